// File: rtl/mux_sel_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mux_pkg
// Brief   : Shared types and constants for the mux_sel_arb arbiter slice.
//           FSM state encoding, source count, grant-id type and the
//           id-to-one-hot select decode.
// Revision: 1.0 - initial release
// ============================================================================
package mux_pkg;

  localparam int NUM_SRC = 3;

  // 0 = no grant, 1..NUM_SRC = index of the granted source
  typedef logic [1:0] gnt_id_t;

  localparam gnt_id_t GNT_NONE       = 2'd0;
  // Reset value of last_gnt: pointing at the last source makes req1 the
  // first candidate of the round-robin search.
  localparam gnt_id_t GNT_RESET_LAST = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Grant index to one-hot select vector (bit0 = sel1).
  function automatic logic [NUM_SRC-1:0] id_to_sel(gnt_id_t id);
    logic [NUM_SRC-1:0] v;
    v = '0;
    case (id)
      2'd1:    v = 3'b001;
      2'd2:    v = 3'b010;
      2'd3:    v = 3'b100;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_sel_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : mux_sel_arb_if
// Brief   : Request/select bundle between request sources and the arbiter.
//           req1..req3, rel : requests and release, driven by the sources
//           sel1..sel3      : one-hot mux select, driven by the arbiter
//           busy, gnt_id    : grant status, driven by the arbiter
//           modport master = source side, modport slave = arbiter side.
// Revision: 1.0 - initial release
// ============================================================================
interface mux_sel_arb_if;
  import mux_pkg::*;

  logic    req1;
  logic    req2;
  logic    req3;
  logic    rel;
  logic    sel1;
  logic    sel2;
  logic    sel3;
  logic    busy;
  gnt_id_t gnt_id;

  modport master (
    output req1, req2, req3, rel,
    input  sel1, sel2, sel3, busy, gnt_id
  );

  modport slave (
    input  req1, req2, req3, rel,
    output sel1, sel2, sel3, busy, gnt_id
  );

endinterface
`default_nettype wire

// File: rtl/mux_sel_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin winner selection.
//           req      [in]  request vector, bit0 = source 1
//           last_gnt [in]  index (1..NUM_SRC) of the previous winner
//           winner   [out] index of the first requester after last_gnt,
//                          GNT_NONE when nobody requests
//           any_req  [out] at least one request is high
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
  import mux_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  gnt_id_t            last_gnt,
  output gnt_id_t            winner,
  output logic               any_req
);

  logic [2:0] w_cand;
  logic [1:0] w_idx;

  assign any_req = |req;

  // Walk the candidates last_gnt+1, last_gnt+2, ... wrapping past NUM_SRC
  // back to 1; the first one found requesting is kept.
  always_comb begin
    winner = GNT_NONE;
    w_cand = '0;
    w_idx  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_cand = {1'b0, last_gnt} + 3'(k);
      if (w_cand > 3'(NUM_SRC)) begin
        w_cand = w_cand - 3'(NUM_SRC);
      end
      w_idx = w_cand[1:0] - 2'd1;
      if ((winner == GNT_NONE) && req[w_idx]) begin
        winner = w_cand[1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_sel_arb.sv
`default_nettype none
// ============================================================================
// Module  : mux_sel_arb
// Brief   : Three-source round-robin arbiter producing a registered one-hot
//           select for a downstream mux. A grant lasts until release, the
//           grantee dropping its request, or HOLD_MAX cycles, and is always
//           followed by one dead cycle with no select high.
//           clk    [in]  clock, rising edge
//           rst_n  [in]  asynchronous active-low reset
//           bus    [slave] req1..3/rel in; sel1..3/busy/gnt_id out (all flops)
//           HOLD_MAX: max consecutive grant cycles, legal range 1..15
// Revision: 1.0 - initial release
// ============================================================================
module mux_sel_arb
  import mux_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_sel_arb_if.slave  bus
);

  localparam int                    c_HOLD_W    = $clog2(HOLD_MAX + 1);
  localparam logic [c_HOLD_W-1:0]   c_HOLD_LAST = c_HOLD_W'(HOLD_MAX - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  gnt_id_t              r_last_gnt;
  gnt_id_t              r_gnt_id;
  gnt_id_t              w_gnt_id_nxt;
  gnt_id_t              w_winner;
  logic [c_HOLD_W-1:0]  r_hold_cnt;
  logic [NUM_SRC-1:0]   w_req;
  logic [NUM_SRC-1:0]   r_sel;
  logic [NUM_SRC-1:0]   w_sel_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 w_any_req;
  logic                 w_grant_exit;

  assign w_req = {bus.req3, bus.req2, bus.req1};

  rr_pick u_rr_pick (
    .req      (w_req),
    .last_gnt (r_last_gnt),
    .winner   (w_winner),
    .any_req  (w_any_req)
  );

  // r_sel is the one-hot of the current grantee, so masking the request
  // vector with it yields the grantee's own request.
  assign w_grant_exit = bus.rel
                      | ~(|(w_req & r_sel))
                      | (r_hold_cnt == c_HOLD_LAST);

  // State and output registers. Outputs are loaded from their next values so
  // nothing downstream sees a combinational path from req/rel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_busy     <= 1'b0;
      r_gnt_id   <= GNT_NONE;
      r_hold_cnt <= '0;
      r_last_gnt <= GNT_RESET_LAST;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_busy   <= w_busy_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      if ((r_state == ST_GRANT) && (w_state_nxt == ST_GRANT)) begin
        r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
      end else begin
        r_hold_cnt <= '0;
      end
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_GRANT)) begin
        r_last_gnt <= w_winner;
      end
    end
  end

  // Next state. Leaving GRANT always passes through IDLE, which is what
  // produces the dead cycle between grants.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_grant_exit) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next outputs. The winner is only taken on entry to GRANT; while the grant
  // is held the current grantee is kept, so other requests are ignored.
  always_comb begin
    w_sel_nxt    = '0;
    w_busy_nxt   = 1'b0;
    w_gnt_id_nxt = GNT_NONE;
    if (w_state_nxt == ST_GRANT) begin
      w_busy_nxt   = 1'b1;
      w_gnt_id_nxt = (r_state == ST_IDLE) ? w_winner : r_gnt_id;
      w_sel_nxt    = id_to_sel(w_gnt_id_nxt);
    end
  end

  assign bus.sel1   = r_sel[0];
  assign bus.sel2   = r_sel[1];
  assign bus.sel3   = r_sel[2];
  assign bus.busy   = r_busy;
  assign bus.gnt_id = r_gnt_id;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_sel_arb
// Brief   : Directed self-checking bench for mux_sel_arb. dut0 uses
//           HOLD_MAX=4, dut1 uses HOLD_MAX=1. Observed vectors are packed as
//           {busy, sel3, sel2, sel1, gnt_id}.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux_sel_arb;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mux_sel_arb_if bus0 ();
  mux_sel_arb_if bus1 ();

  mux_sel_arb #(.HOLD_MAX(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  mux_sel_arb #(.HOLD_MAX(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected packed vector for a given grant index (0 = none).
  function automatic logic [5:0] exp_vec(int id);
    case (id)
      1:       return 6'b1_001_01;
      2:       return 6'b1_010_10;
      3:       return 6'b1_100_11;
      default: return 6'b0_000_00;
    endcase
  endfunction

  function automatic logic [5:0] obs0();
    return {bus0.busy, bus0.sel3, bus0.sel2, bus0.sel1, bus0.gnt_id};
  endfunction

  function automatic logic [5:0] obs1();
    return {bus1.busy, bus1.sel3, bus1.sel2, bus1.sel1, bus1.gnt_id};
  endfunction

  // Independent consistency rule: at most one select, gnt_id names it,
  // busy equals "some select high".
  function automatic logic consistent(logic [5:0] v);
    logic [2:0] s;
    logic [1:0] g;
    s = v[4:2];
    g = v[1:0];
    case (s)
      3'b000:  return (g == 2'd0) && !v[5];
      3'b001:  return (g == 2'd1) &&  v[5];
      3'b010:  return (g == 2'd2) &&  v[5];
      3'b100:  return (g == 2'd3) &&  v[5];
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    checks++;
    if (consistent(obs0()) !== 1'b1) begin
      failures++;
      $display("FAIL onehot_dut0 t=%0t: got %b, required a consistent one-hot vector", $time, obs0());
    end
    checks++;
    if (consistent(obs1()) !== 1'b1) begin
      failures++;
      $display("FAIL onehot_dut1 t=%0t: got %b, required a consistent one-hot vector", $time, obs1());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(logic r1, logic r2, logic r3, logic rl);
    bus0.req1 = r1;
    bus0.req2 = r2;
    bus0.req3 = r3;
    bus0.rel  = rl;
  endtask

  task automatic drive1(logic r1, logic r2, logic r3, logic rl);
    bus1.req1 = r1;
    bus1.req2 = r2;
    bus1.req3 = r3;
    bus1.rel  = rl;
  endtask

  task automatic do_reset();
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Outputs cleared by reset, held through an edge, unchanged until the
  // first edge after release, then req1 granted.
  task automatic test_reset();
    drive0(1, 0, 0, 0);
    #1;
    checks++;
    if (obs0() !== exp_vec(0)) begin
      failures++;
      $display("FAIL reset_async: got %b required %b", obs0(), exp_vec(0));
    end
    step();
    checks++;
    if (obs0() !== exp_vec(0)) begin
      failures++;
      $display("FAIL reset_held: got %b required %b", obs0(), exp_vec(0));
    end
    rst_n = 1'b1;
    #2;
    checks++;
    if (obs0() !== exp_vec(0)) begin
      failures++;
      $display("FAIL reset_release_no_change: got %b required %b", obs0(), exp_vec(0));
    end
    step();
    checks++;
    if (obs0() !== exp_vec(1)) begin
      failures++;
      $display("FAIL reset_first_grant: got %b required %b", obs0(), exp_vec(1));
    end
  endtask

  // req1 only, then rel with req drop in the same cycle, then idle.
  task automatic test_single();
    int exp_ids[3] = '{1, 0, 0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive0(1, 0, 0, 0);
        1:       drive0(0, 0, 0, 1);
        default: drive0(0, 0, 0, 0);
      endcase
      step();
      checks++;
      if (obs0() !== exp_vec(exp_ids[i])) begin
        failures++;
        $display("FAIL single step %0d: got %b required %b", i, obs0(), exp_vec(exp_ids[i]));
      end
    end
  endtask

  // HOLD_MAX=4 with req1 and req2 held: 4 cycles each, single dead cycles.
  task automatic test_hold();
    int exp_ids[11] = '{1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 1};
    do_reset();
    drive0(1, 1, 0, 0);
    for (int i = 0; i < 11; i++) begin
      step();
      checks++;
      if (obs0() !== exp_vec(exp_ids[i])) begin
        failures++;
        $display("FAIL hold step %0d: got %b required %b", i, obs0(), exp_vec(exp_ids[i]));
      end
    end
  endtask

  // All requests with rel held high: rel ends each grant after one cycle
  // and is ignored while idle.
  task automatic test_rotate();
    int exp_ids[7] = '{1, 0, 2, 0, 3, 0, 1};
    do_reset();
    drive0(1, 1, 1, 1);
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (obs0() !== exp_vec(exp_ids[i])) begin
        failures++;
        $display("FAIL rotate step %0d: got %b required %b", i, obs0(), exp_vec(exp_ids[i]));
      end
    end
  endtask

  // req3 raised during sel2 is ignored; req2 drop ends the grant, dead cycle,
  // then sel3; rel plus req3 drop together give a single exit.
  task automatic test_handoff();
    int exp_ids[6] = '{2, 2, 0, 3, 0, 0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       drive0(0, 1, 0, 0);
        1:       drive0(0, 1, 1, 0);
        2:       drive0(0, 0, 1, 0);
        3:       drive0(0, 0, 1, 0);
        4:       drive0(0, 0, 0, 1);
        default: drive0(0, 0, 0, 0);
      endcase
      step();
      checks++;
      if (obs0() !== exp_vec(exp_ids[i])) begin
        failures++;
        $display("FAIL handoff step %0d: got %b required %b", i, obs0(), exp_vec(exp_ids[i]));
      end
    end
  endtask

  // Reset between edges mid-grant; after release req1 wins again.
  task automatic test_async_reset();
    do_reset();
    drive0(1, 1, 1, 0);
    step();
    checks++;
    if (obs0() !== exp_vec(1)) begin
      failures++;
      $display("FAIL areset_pre_grant: got %b required %b", obs0(), exp_vec(1));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs0() !== exp_vec(0)) begin
      failures++;
      $display("FAIL areset_immediate: got %b required %b", obs0(), exp_vec(0));
    end
    step();
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs0() !== exp_vec(0)) begin
      failures++;
      $display("FAIL areset_before_edge: got %b required %b", obs0(), exp_vec(0));
    end
    step();
    checks++;
    if (obs0() !== exp_vec(1)) begin
      failures++;
      $display("FAIL areset_restart_req1: got %b required %b", obs0(), exp_vec(1));
    end
  endtask

  // HOLD_MAX=1: single-cycle grants separated by single dead cycles.
  task automatic test_hold1();
    int exp_ids[5] = '{1, 0, 2, 0, 1};
    do_reset();
    drive1(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs1() !== exp_vec(exp_ids[i])) begin
        failures++;
        $display("FAIL hold1 step %0d: got %b required %b", i, obs1(), exp_vec(exp_ids[i]));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_hold();
    test_rotate();
    test_handoff();
    test_async_reset();
    test_hold1();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
